flipflop_d_checker: RTL



---
 rtl/flipflop_d_checker_pkg.sv | 43 ++++
 rtl/flipflop_d_checker_model.sv | 34 +++
 rtl/flipflop_d_checker.sv | 107 ++++++++++
 3 files changed

// File: rtl/flipflop_d_checker_pkg.sv
// Shared types and helpers for the D flip-flop response checker.
// Holds the FSM state enum, override codes and the override-to-pair map.
package flipflop_d_checker_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN,
    DONE
  } state_t;

  // Override code: bit1 = preset asserted, bit0 = clear asserted
  typedef logic [1:0] ovr_t;

  localparam ovr_t OVR_NONE = 2'b00;
  localparam ovr_t OVR_CLR  = 2'b01;
  localparam ovr_t OVR_SET  = 2'b10;
  localparam ovr_t OVR_BOTH = 2'b11;

  function automatic ovr_t ovr_decode(
    input logic preset,
    input logic clear
  );
    return {~preset, ~clear};
  endfunction

  // Returns {q, q_not} forced by the async pins.
  // OVR_NONE yields 2'b00; callers must not use it.
  function automatic logic [1:0] ovr_pair(
    input logic preset,
    input logic clear
  );
    logic [1:0] pair;
    unique case (ovr_decode(preset, clear))
      OVR_SET:  pair = 2'b10;
      OVR_CLR:  pair = 2'b01;
      OVR_BOTH: pair = 2'b11;
      default:  pair = 2'b00;
    endcase
    return pair;
  endfunction

endpackage

// File: rtl/flipflop_d_checker_model.sv
// Golden model of the D flip-flop with active-low async preset/clear.
// Ports: clk, reset, d/preset/clear (as driven), exp_pair = {q, q_not} expected now.
import flipflop_d_checker_pkg::*;

module flipflop_d_model (
  input  logic       clk,
  input  logic       reset,
  input  logic       d,
  input  logic       preset,
  input  logic       clear,
  output logic [1:0] exp_pair
);

  logic       exp_q;
  logic       ovr_on;
  logic [1:0] ovr_val;

  assign ovr_on  = ovr_decode(preset, clear) != OVR_NONE;
  assign ovr_val = ovr_pair(preset, clear);

  always_ff @(posedge clk) begin
    if (reset) begin
      exp_q <= 1'b0;
    end else if (ovr_on) begin
      exp_q <= ovr_val[1];
    end else begin
      exp_q <= d;
    end
  end

  // Overrides act combinationally; otherwise Q shows the last capture
  assign exp_pair = ovr_on ? ovr_val : {exp_q, ~exp_q};

endmodule

// File: rtl/flipflop_d_checker.sv
// Response checker for a D flip-flop: compares q/q_not to a golden model.
// Ports: start/stop run control, DUT stimulus + outputs in; busy/done/pass, counters out.
import flipflop_d_checker_pkg::*;

module flipflop_d_checker #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             d,
  input  logic             preset,
  input  logic             clear,
  input  logic             q,
  input  logic             q_not,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] check_count,
  output logic [CNT_W-1:0] first_err
);

  state_t     state;
  state_t     state_n;
  logic [1:0] exp_pair;
  logic       fail;
  logic       cmp_en;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  flipflop_d_model u_model (
    .clk      (clk),
    .reset    (reset),
    .d        (d),
    .preset   (preset),
    .clear    (clear),
    .exp_pair (exp_pair)
  );

  assign fail = {q, q_not} != exp_pair;

  // A restart pulse in RUN skips the compare; ARM wipes results anyway
  assign cmp_en = (state == RUN) && !start;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start) state_n = ARM;
      ARM:  state_n = RUN;
      RUN: begin
        if (start) begin
          state_n = ARM;
        end else if (stop) begin
          state_n = DONE;
        end
      end
      DONE: if (start) state_n = ARM;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mismatch    <= 1'b0;
      err_count   <= '0;
      check_count <= '0;
      first_err   <= '1;
    end else begin
      mismatch <= 1'b0;
      if (state == ARM) begin
        err_count   <= '0;
        check_count <= '0;
        first_err   <= '1;
      end else if (cmp_en) begin
        check_count <= sat_inc(check_count);
        if (fail) begin
          mismatch  <= 1'b1;
          err_count <= sat_inc(err_count);
          // err_count saturates, so zero means no error yet
          if (err_count == '0) begin
            first_err <= check_count;
          end
        end
      end
    end
  end

  assign busy = (state == ARM) || (state == RUN);
  assign done = state == DONE;
  assign pass = done && (err_count == '0) && (check_count != '0);

endmodule
